rbr_accumulator: RTL
====================

Name: rbr_accumulator

Overview:
- Downstream consumer of the 4-bit RBR encoder output (code 0..9 per sensing phase).
- Input operands are applied bit-serially, MSB slice first; each slice yields one encoded code.
- Shift-adds the per-slice codes into one multi-bit MAC result: result = sum(code_k << (N-1-k)).
- Hands the result to the peripheral/bus side through a valid/ready handshake.

Parameters:
- ACC_W, 16, accumulator and result width in bits.
- MAX_SLICES, 8, maximum bit-slices per job. CNT_W = $clog2(MAX_SLICES+1) is derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  job start pulse; honoured only in IDLE, or in DONE on the same cycle as a result handshake.
- num_slices_i  in  CNT_W  slice count for the job; sampled only when start is accepted.
- code_valid_i  in  1  code_i valid this cycle.
- code_i  in  4  encoded code from the RBR encoder.
- busy_o  out  1  high in ACCUM.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  consumer accepts the result.
- result_o  out  ACC_W  accumulated result.
- ovf_o  out  1  overflow flag for the current result.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; acc, slice counter, result_o, ovf_o, busy_o and result_valid_o all 0.
  - A reset mid-job aborts the job immediately; no partial result is produced.
- States:
  - IDLE:
    - start_i=1 latches n = min(num_slices_i, MAX_SLICES), clears acc and ovf, and moves to ACCUM.
    - If n=0, moves directly to DONE instead, with result 0 and result_valid_o high the next cycle.
  - ACCUM:
    - Each cycle with code_valid_i=1: acc <= (acc<<1) + zero-extended code_i, and the counter increments.
    - code_valid_i=0: acc and counter hold, with no timeout.
    - When the n-th code is accepted, moves to DONE.
    - start_i is ignored.
  - DONE:
    - result_valid_o=1; result_o and ovf_o are stable until handshake.
    - result_valid_o & result_ready_i: goes to IDLE. If start_i is also high that cycle, the new job is accepted and the block goes directly to ACCUM (or DONE if n=0).
    - code_valid_i is ignored.
- Latency:
  - Last code accepted at edge t: result_valid_o=1 after edge t (registered); result_o is registered from the final acc value.
  - One slice per cycle at full throughput; minimum job time is n+1 cycles including the handshake.
- Arithmetic:
  - Unsigned; acc is ACC_W bits.
  - code_i values 10..15 (not produced by the encoder) are accumulated as-is, with no check.
  - Overflow handling is per the Optional Feature.
- code_valid_i in IDLE is dropped silently.
- result_valid_o never deasserts without a handshake, except on reset.

Optional Feature:
- Macro: RBR_ACC_SAT_EN.
- Defined:
  - Each shift-add step is computed at ACC_W+4 bits.
  - If the step exceeds 2^ACC_W-1, acc clamps to all-ones and the sticky ovf is set for the job.
  - All subsequent steps stay at all-ones.
  - ovf_o = sticky ovf, valid with result_valid_o.
- Undefined:
  - acc wraps modulo 2^ACC_W.
  - ovf_o is tied 0.

Test Plan:
- 4-slice job with no stall (ACC_W=16): start_i, n=4; codes 9,6,4,0 on consecutive cycles -> result_o=104, result_valid_o high 1 cycle after the 4th code; busy_o high exactly 4 cycles.
- Stalls and backpressure: n=3; codes 1,0,1 with code_valid_i low 2 cycles between each; result_ready_i held low 5 cycles -> result_o=5 held stable, result_valid_o stays high until ready; start_i pulsed during ACCUM has no effect.
- Overflow, ACC_W=8, n=8, all codes 9:
  - With RBR_ACC_SAT_EN -> result_o=255, ovf_o=1.
  - Without -> result_o=247, ovf_o=0.
- Edge counts and back-to-back:
  - n=0 -> result 0 one cycle after start.
  - num_slices_i=15 (MAX_SLICES=8) -> exactly 8 codes consumed.
  - start_i together with a result handshake -> new job begins with no idle cycle.
- Reset mid-job: assert rst_ni=0 after 2 of 4 codes -> all outputs 0 immediately (asynchronous); after release, a fresh job of codes 2,3 (n=2) gives result_o=7.

Source files
------------

// File: rtl/rbr_accumulator.sv
// Bit-serial shift-add accumulator for RBR encoder codes, with a valid/ready result port.
// Optional macro RBR_ACC_SAT_EN: saturate at all-ones and raise a sticky ovf_o instead of wrapping.
module rbr_accumulator #(
   parameter  int ACC_W      = 16,
   parameter  int MAX_SLICES = 8,
   localparam int CNT_W      = $clog2(MAX_SLICES + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [CNT_W-1:0] num_slices_i,
   input  logic             code_valid_i,
   input  logic [3:0]       code_i,
   output logic             busy_o,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [ACC_W-1:0] result_o,
   output logic             ovf_o
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_SLICES);

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   result_q, result_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   n_q, n_d;
   logic [CNT_W-1:0]   n_req, cnt_inc;
   logic [ACC_W-1:0]   acc_step;
   logic               step_ovf;
   logic               launch;
   logic               step_en;

   assign n_req   = (num_slices_i > MAX_N) ? MAX_N : num_slices_i;
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign launch  = start_i && ((state_q == IDLE) || (state_q == DONE && result_ready_i));
   assign step_en = (state_q == ACCUM) && code_valid_i;

`ifdef RBR_ACC_SAT_EN
   logic [ACC_W+3:0] wide;
   logic             ovf_q, ovf_d;

   // Once clamped, all-ones shifted left always exceeds the range, so it stays clamped.
   assign wide     = ({4'b0, acc_q} << 1) + (ACC_W+4)'(code_i);
   assign step_ovf = |wide[ACC_W+3:ACC_W];
   assign acc_step = step_ovf ? '1 : wide[ACC_W-1:0];

   always_comb begin
      ovf_d = ovf_q;
      if (launch)                   ovf_d = 1'b0;
      else if (step_en && step_ovf) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ovf_q <= 1'b0;
      else         ovf_q <= ovf_d;
   end

   assign ovf_o = ovf_q;
`else
   assign step_ovf = 1'b0;
   assign acc_step = (acc_q << 1) + ACC_W'(code_i);
   assign ovf_o    = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (launch) state_d = (n_req == '0) ? DONE : ACCUM;
         ACCUM: if (step_en && cnt_inc == n_q) state_d = DONE;
         DONE: begin
            if (launch)              state_d = (n_req == '0) ? DONE : ACCUM;
            else if (result_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy_o         = (state_q == ACCUM);
      result_valid_o = (state_q == DONE);
      result_o       = result_q;
   end

   // Datapath
   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      result_d = result_q;
      if (launch) begin
         acc_d = '0;
         cnt_d = '0;
         n_d   = n_req;
         if (n_req == '0) result_d = '0;
      end else if (step_en) begin
         acc_d = acc_step;
         cnt_d = cnt_inc;
         if (cnt_inc == n_q) result_d = acc_step;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         n_q      <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         result_q <= result_d;
      end
   end

endmodule
